// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB definitions: register-file macros, CDB_T_PACKET and FU_RESULT.
// The optional CDB_PERF_EN build adds performance counters to cdb_broadcaster.
`ifndef CDB_SYS_DEFS
`define CDB_SYS_DEFS
`define PR      6
`define XLEN    32
`define ZERO_PR 6'd0
`endif

package cdb_broadcaster_pkg;

    localparam int unsigned PR_W      = `PR;
    localparam int unsigned XLEN_W    = `XLEN;
    localparam int unsigned CDB_LANES = 3;
    localparam logic [PR_W-1:0] ZERO_PR = `ZERO_PR;

    typedef struct packed {
        logic [PR_W-1:0] t0;
        logic [PR_W-1:0] t1;
        logic [PR_W-1:0] t2;
    } CDB_T_PACKET;

    typedef struct packed {
        logic              valid;
        logic [PR_W-1:0]   tag;
        logic [XLEN_W-1:0] data;
    } FU_RESULT;

    function automatic logic [31:0] lane_count(input logic [CDB_LANES-1:0] lv);
        logic [31:0] n;
        n = '0;
        for (int unsigned l = 0; l < CDB_LANES; l++) begin
            n = n + 32'(lv[l]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_pick3.sv
// Combinational round-robin selector: picks up to three full slots starting at
// rr_ptr and returns one-hot grants per lane plus the following pointer.
module rr_pick3
    import cdb_broadcaster_pkg::*;
#(
    parameter int unsigned N_FU = 8,
    localparam int unsigned PTR_W = $clog2(N_FU)
) (
    input  logic [N_FU-1:0]                 full,
    input  logic [PTR_W-1:0]                rr_ptr,
    output logic [CDB_LANES-1:0][N_FU-1:0]  grant,
    output logic [CDB_LANES-1:0]            lane_valid,
    output logic [PTR_W-1:0]                next_ptr
);

    localparam logic [PTR_W:0]   N_SZ = (PTR_W+1)'(N_FU);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_FU - 1);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [1:0]       found;

    always_comb begin
        grant      = '0;
        lane_valid = '0;
        next_ptr   = rr_ptr;
        found      = '0;
        sum        = '0;
        idx        = '0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= N_SZ) begin
                sum = sum - N_SZ;
            end
            idx = sum[PTR_W-1:0];
            if (full[idx] && (found != 2'd3)) begin
                grant[found][idx] = 1'b1;
                lane_valid[found] = 1'b1;
                found             = found + 2'd1;
                next_ptr          = (idx == LAST) ? '0 : idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// 3-wide CDB transmit side: one holding slot per FU, round-robin pick of up to
// three results per cycle into registered tag/data lanes. Optional: CDB_PERF_EN.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int unsigned N_FU  = 8,
    parameter int unsigned LANES = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_FU-1:0]                fu_valid,
    input  logic [N_FU-1:0][PR_W-1:0]      fu_tag,
    input  logic [N_FU-1:0][XLEN_W-1:0]    fu_data,
    output logic [N_FU-1:0]                fu_ready,
    input  logic                           squash,
    output CDB_T_PACKET                    cdb_packet,
    output logic [2:0][XLEN_W-1:0]         cdb_data
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]                    perf_bcast_cnt,
    output logic [31:0]                    perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(N_FU);

    FU_RESULT                         slot [N_FU];
    logic [N_FU-1:0]                  full;
    logic [PTR_W-1:0]                 rr_ptr;
    logic [CDB_LANES-1:0][N_FU-1:0]   grant;
    logic [CDB_LANES-1:0]             lane_valid;
    logic [PTR_W-1:0]                 next_ptr;
    logic [N_FU-1:0]                  grant_any;
    logic [N_FU-1:0]                  accept;
    logic [CDB_LANES-1:0][PR_W-1:0]   lane_tag;
    logic [CDB_LANES-1:0][XLEN_W-1:0] lane_data;

    rr_pick3 #(.N_FU(N_FU)) u_pick (
        .full       (full),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .lane_valid (lane_valid),
        .next_ptr   (next_ptr)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_FU; i++) begin
            full[i] = slot[i].valid;
        end
    end

    assign grant_any = grant[0] | grant[1] | grant[2];
    assign fu_ready  = ~full | grant_any;
    assign accept    = fu_valid & fu_ready;

    // Grants are one-hot per lane, so OR-ing the masked slots forms the mux.
    always_comb begin
        lane_tag  = '0;
        lane_data = '0;
        for (int unsigned l = 0; l < CDB_LANES; l++) begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                if (grant[l][i]) begin
                    lane_tag[l]  = lane_tag[l]  | slot[i].tag;
                    lane_data[l] = lane_data[l] | slot[i].data;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                slot[i] <= '0;
            end
            rr_ptr        <= '0;
            cdb_packet.t0 <= ZERO_PR;
            cdb_packet.t1 <= ZERO_PR;
            cdb_packet.t2 <= ZERO_PR;
            cdb_data      <= '0;
        end else if (squash) begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                slot[i].valid <= 1'b0;
            end
            rr_ptr        <= '0;
            cdb_packet.t0 <= ZERO_PR;
            cdb_packet.t1 <= ZERO_PR;
            cdb_packet.t2 <= ZERO_PR;
            cdb_data      <= '0;
        end else begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                if (accept[i] && (fu_tag[i] != ZERO_PR)) begin
                    slot[i].valid <= 1'b1;
                    slot[i].tag   <= fu_tag[i];
                    slot[i].data  <= fu_data[i];
                end else if (grant_any[i]) begin
                    slot[i].valid <= 1'b0;
                end
            end
            rr_ptr        <= next_ptr;
            cdb_packet.t0 <= lane_valid[0] ? lane_tag[0] : ZERO_PR;
            cdb_packet.t1 <= lane_valid[1] ? lane_tag[1] : ZERO_PR;
            cdb_packet.t2 <= lane_valid[2] ? lane_tag[2] : ZERO_PR;
            cdb_data      <= lane_data;
        end
    end

`ifdef CDB_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_bcast_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (!squash) begin
                perf_bcast_cnt <= perf_bcast_cnt + lane_count(lane_valid);
            end
            if (|(fu_valid & ~fu_ready)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
